maze_tile_scheduler: RTL and testbench

- Owns the 13x19 maze tile map and sequences every change to it: bomb placement, and the explosion sweep that clears bricks and emits flame tiles.
- Arbitrates map writes between the bomb-placement requester and the explosion requester.
- Serves a read-only tile query port used by player collision logic.
- Sits between the player/bomb controllers and the maze drawing/collision path.

---
 rtl/maze_pkg.sv | 32 +++
 rtl/maze_tile_ram.sv | 59 +++++
 rtl/maze_tile_scheduler.sv | 243 ++++++++++++++++++++++++
 tb/tb_maze_tile_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared tile/direction types and the power-on maze layout.
package maze_pkg;

  localparam int unsigned MAZE_ROWS = 13;
  localparam int unsigned MAZE_COLS = 19;
  localparam int unsigned ROW_W     = 4;
  localparam int unsigned COL_W     = 5;
  localparam int unsigned STEP_W    = 3;
  localparam int unsigned COORD_W   = 6;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HARD  = 2'd1,
    BRICK = 2'd2,
    BOMB  = 2'd3
  } tile_t;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  // Pillars on odd/odd, a brick column every fourth column on even rows.
  function automatic tile_t defaultTile(input int unsigned row, input int unsigned col);
    if ((row % 2) == 1 && (col % 2) == 1) return HARD;
    if ((row % 2) == 0 && (col % 4) == 3) return BRICK;
    return EMPTY;
  endfunction

endpackage

// File: rtl/maze_tile_ram.sv
// Flip-flop tile map: reset-to-layout, one write port, a combinational sweep
// read port and a registered query port (out-of-range reads return HARD).
module maze_tile_ram
  import maze_pkg::*;
#(
  parameter int unsigned ROWS = MAZE_ROWS,
  parameter int unsigned COLS = MAZE_COLS
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             wrEn,
  input  logic [ROW_W-1:0] wrRow,
  input  logic [COL_W-1:0] wrCol,
  input  tile_t            wrTile,
  input  logic [ROW_W-1:0] rdRow,
  input  logic [COL_W-1:0] rdCol,
  output tile_t            rdTile_c,
  input  logic             qryValid,
  input  logic [ROW_W-1:0] qryRow,
  input  logic [COL_W-1:0] qryCol,
  output tile_t            qryTile,
  output logic             qryRvalid
);

  localparam logic [ROW_W-1:0] ROWS_L = ROW_W'(ROWS);
  localparam logic [COL_W-1:0] COLS_L = COL_W'(COLS);

  tile_t mapQ [ROWS][COLS];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          mapQ[r][c] <= defaultTile(r, c);
        end
      end
    end else begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          if (wrEn && wrRow == ROW_W'(r) && wrCol == COL_W'(c)) mapQ[r][c] <= wrTile;
        end
      end
    end
  end

  assign rdTile_c = (rdRow < ROWS_L && rdCol < COLS_L) ? mapQ[rdRow][rdCol] : HARD;

  // Query sees the map as it stood before this edge's write.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      qryTile   <= EMPTY;
      qryRvalid <= 1'b0;
    end else begin
      qryRvalid <= qryValid;
      if (qryValid) qryTile <= (qryRow < ROWS_L && qryCol < COLS_L) ? mapQ[qryRow][qryCol] : HARD;
    end
  end

endmodule

// File: rtl/maze_tile_scheduler.sv
// Maze map owner: arbitrates bomb placement against explosion sweeps and
// streams flame tiles while clearing bricks along each direction.
module maze_tile_scheduler
  import maze_pkg::*;
#(
  parameter int unsigned ROWS   = MAZE_ROWS,
  parameter int unsigned COLS   = MAZE_COLS,
  parameter int unsigned RADIUS = 2
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       place_req,
  input  logic [3:0] place_row,
  input  logic [4:0] place_col,
  output logic       place_ack,
  output logic       place_ok,
  input  logic       explode_req,
  input  logic [3:0] explode_row,
  input  logic [4:0] explode_col,
  output logic       explode_ack,
  output logic       explode_busy,
  output logic       explode_done,
  output logic       flame_valid,
  output logic [3:0] flame_row,
  output logic [4:0] flame_col,
  output logic       chain_hit,
  input  logic       qry_valid,
  input  logic [3:0] qry_row,
  input  logic [4:0] qry_col,
  output logic [1:0] qry_tile,
  output logic       qry_rvalid
);

  typedef enum logic [2:0] {IDLE, PLACE, CENTER, UP, DOWN, LEFT, RIGHT, DONE} state_t;

  localparam logic signed [COORD_W-1:0] ROWS_S   = COORD_W'(ROWS);
  localparam logic signed [COORD_W-1:0] COLS_S   = COORD_W'(COLS);
  localparam logic [STEP_W-1:0]         RADIUS_L = STEP_W'(RADIUS);

  state_t             stateQ, stateD;
  logic [STEP_W-1:0]  stepQ, stepD;
  logic               termQ, termD;
  logic [ROW_W-1:0]   expRowQ, expRowD;
  logic [COL_W-1:0]   expColQ, expColD;
  logic               placeAckQ, placeAckD, placeOkQ, placeOkD;
  logic               explodeAckQ, explodeAckD, explodeBusyQ, explodeBusyD;
  logic               explodeDoneQ, explodeDoneD, chainHitQ, chainHitD;
  logic               flameValidQ, flameValidD;
  logic [ROW_W-1:0]   flameRowQ, flameRowD;
  logic [COL_W-1:0]   flameColQ, flameColD;

  logic               wrEn_c;
  logic [ROW_W-1:0]   wrRow_c, rdRow_c;
  logic [COL_W-1:0]   wrCol_c, rdCol_c;
  tile_t              wrTile_c, rdTile_c, qryTileW;
  dir_t               dir_c;
  logic signed [COORD_W-1:0] tgtRow_c, tgtCol_c, stepS_c;
  logic               tgtInRange_c;

  maze_tile_ram #(.ROWS(ROWS), .COLS(COLS)) u_ram (
    .clk      (clk),
    .resetN   (resetN),
    .wrEn     (wrEn_c),
    .wrRow    (wrRow_c),
    .wrCol    (wrCol_c),
    .wrTile   (wrTile_c),
    .rdRow    (rdRow_c),
    .rdCol    (rdCol_c),
    .rdTile_c (rdTile_c),
    .qryValid (qry_valid),
    .qryRow   (qry_row),
    .qryCol   (qry_col),
    .qryTile  (qryTileW),
    .qryRvalid(qry_rvalid)
  );

  // Target tile of the current sweep step, with signed range check.
  always_comb begin
    case (stateQ)
      DOWN:    dir_c = DIR_DOWN;
      LEFT:    dir_c = DIR_LEFT;
      RIGHT:   dir_c = DIR_RIGHT;
      default: dir_c = DIR_UP;
    endcase
    stepS_c  = $signed(COORD_W'(stepQ));
    tgtRow_c = $signed(COORD_W'(expRowQ));
    tgtCol_c = $signed(COORD_W'(expColQ));
    case (dir_c)
      DIR_UP:    tgtRow_c = tgtRow_c - stepS_c;
      DIR_DOWN:  tgtRow_c = tgtRow_c + stepS_c;
      DIR_LEFT:  tgtCol_c = tgtCol_c - stepS_c;
      default:   tgtCol_c = tgtCol_c + stepS_c;
    endcase
    tgtInRange_c = !tgtRow_c[COORD_W-1] && (tgtRow_c < ROWS_S) &&
                   !tgtCol_c[COORD_W-1] && (tgtCol_c < COLS_S);
  end

  always_comb begin
    stateD       = stateQ;
    stepD        = stepQ;
    termD        = termQ;
    expRowD      = expRowQ;
    expColD      = expColQ;
    placeAckD    = 1'b0;
    placeOkD     = 1'b0;
    explodeAckD  = 1'b0;
    explodeBusyD = 1'b0;
    explodeDoneD = 1'b0;
    flameValidD  = 1'b0;
    flameRowD    = flameRowQ;
    flameColD    = flameColQ;
    chainHitD    = 1'b0;
    wrEn_c       = 1'b0;
    wrRow_c      = expRowQ;
    wrCol_c      = expColQ;
    wrTile_c     = EMPTY;
    rdRow_c      = tgtRow_c[ROW_W-1:0];
    rdCol_c      = tgtCol_c[COL_W-1:0];

    case (stateQ)
      IDLE: begin
        rdRow_c = place_row;
        rdCol_c = place_col;
        if (explode_req) begin
          stateD      = CENTER;
          explodeAckD = 1'b1;
          expRowD     = explode_row;
          expColD     = explode_col;
        end else if (place_req) begin
          // Place decision and bomb write land on the edge into PLACE.
          stateD    = PLACE;
          placeAckD = 1'b1;
          if (rdTile_c == EMPTY) begin
            placeOkD = 1'b1;
            wrEn_c   = 1'b1;
            wrRow_c  = place_row;
            wrCol_c  = place_col;
            wrTile_c = BOMB;
          end
        end
      end
      PLACE: stateD = IDLE;
      CENTER: begin
        explodeBusyD = 1'b1;
        wrEn_c       = 1'b1;
        flameValidD  = 1'b1;
        flameRowD    = expRowQ;
        flameColD    = expColQ;
        stateD       = UP;
        stepD        = STEP_W'(1);
        termD        = 1'b0;
      end
      UP, DOWN, LEFT, RIGHT: begin
        explodeBusyD = 1'b1;
        if (!termQ) begin
          if (!tgtInRange_c || rdTile_c == HARD) begin
            termD = 1'b1;
          end else begin
            flameValidD = 1'b1;
            flameRowD   = tgtRow_c[ROW_W-1:0];
            flameColD   = tgtCol_c[COL_W-1:0];
            case (rdTile_c)
              BRICK: begin
                wrEn_c  = 1'b1;
                wrRow_c = tgtRow_c[ROW_W-1:0];
                wrCol_c = tgtCol_c[COL_W-1:0];
                termD   = 1'b1;
              end
              BOMB: begin
                chainHitD = 1'b1;
                termD     = 1'b1;
              end
              default: ;
            endcase
          end
        end
        if (stepQ == RADIUS_L) begin
          stepD = STEP_W'(1);
          termD = 1'b0;
          case (stateQ)
            UP:      stateD = DOWN;
            DOWN:    stateD = LEFT;
            LEFT:    stateD = RIGHT;
            default: stateD = DONE;
          endcase
        end else begin
          stepD = stepQ + STEP_W'(1);
        end
      end
      DONE: begin
        explodeDoneD = 1'b1;
        stateD       = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stateQ       <= IDLE;
      stepQ        <= '0;
      termQ        <= 1'b0;
      expRowQ      <= '0;
      expColQ      <= '0;
      placeAckQ    <= 1'b0;
      placeOkQ     <= 1'b0;
      explodeAckQ  <= 1'b0;
      explodeBusyQ <= 1'b0;
      explodeDoneQ <= 1'b0;
      flameValidQ  <= 1'b0;
      flameRowQ    <= '0;
      flameColQ    <= '0;
      chainHitQ    <= 1'b0;
    end else begin
      stateQ       <= stateD;
      stepQ        <= stepD;
      termQ        <= termD;
      expRowQ      <= expRowD;
      expColQ      <= expColD;
      placeAckQ    <= placeAckD;
      placeOkQ     <= placeOkD;
      explodeAckQ  <= explodeAckD;
      explodeBusyQ <= explodeBusyD;
      explodeDoneQ <= explodeDoneD;
      flameValidQ  <= flameValidD;
      flameRowQ    <= flameRowD;
      flameColQ    <= flameColD;
      chainHitQ    <= chainHitD;
    end
  end

  assign place_ack    = placeAckQ;
  assign place_ok     = placeOkQ;
  assign explode_ack  = explodeAckQ;
  assign explode_busy = explodeBusyQ;
  assign explode_done = explodeDoneQ;
  assign flame_valid  = flameValidQ;
  assign flame_row    = flameRowQ;
  assign flame_col    = flameColQ;
  assign chain_hit    = chainHitQ;
  assign qry_tile     = qryTileW;

endmodule

// File: tb/tb_maze_tile_scheduler.sv
// Scoreboard bench: a tile-map reference model queues expected flames, place
// results and query tiles; a negedge monitor pops and compares DUT outputs.
`timescale 1ns/1ps
module tb_maze_tile_scheduler;

  localparam int R  = 2;
  localparam int NR = 13;
  localparam int NC = 19;
  localparam int T_EMPTY = 0, T_HARD = 1, T_BRICK = 2, T_BOMB = 3;

  logic       clk = 1'b0, resetN = 1'b0;
  logic       place_req = 1'b0, explode_req = 1'b0, qry_valid = 1'b0;
  logic [3:0] place_row = '0, explode_row = '0, qry_row = '0;
  logic [4:0] place_col = '0, explode_col = '0, qry_col = '0;
  logic       place_ack, place_ok, explode_ack, explode_busy, explode_done;
  logic       flame_valid, chain_hit, qry_rvalid;
  logic [3:0] flame_row;
  logic [4:0] flame_col;
  logic [1:0] qry_tile;

  maze_tile_scheduler #(.ROWS(NR), .COLS(NC), .RADIUS(R)) dut (
    .clk(clk), .resetN(resetN),
    .place_req(place_req), .place_row(place_row), .place_col(place_col),
    .place_ack(place_ack), .place_ok(place_ok),
    .explode_req(explode_req), .explode_row(explode_row), .explode_col(explode_col),
    .explode_ack(explode_ack), .explode_busy(explode_busy), .explode_done(explode_done),
    .flame_valid(flame_valid), .flame_row(flame_row), .flame_col(flame_col),
    .chain_hit(chain_hit),
    .qry_valid(qry_valid), .qry_row(qry_row), .qry_col(qry_col),
    .qry_tile(qry_tile), .qry_rvalid(qry_rvalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0, mismatched = 0;
  int refMap [NR][NC];
  int flameQ[$];
  int placeQ[$];
  int qryQ[$];
  int qryCycQ[$];
  bit sweepUnchecked = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic failNote(input string name, input int act);
    compared++;
    mismatched++;
    $display("FAIL %s: unexpected output value %0d (t=%0t)", name, act, $time);
  endtask

  function automatic int layoutTile(int r, int c);
    if (r % 2 == 1 && c % 2 == 1) return T_HARD;
    if (r % 2 == 0 && c % 4 == 3) return T_BRICK;
    return T_EMPTY;
  endfunction

  function automatic void modelReset();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        refMap[r][c] = layoutTile(r, c);
  endfunction

  function automatic int modelPlace(int r, int c);
    if (r < NR && c < NC && refMap[r][c] == T_EMPTY) begin
      refMap[r][c] = T_BOMB;
      return 1;
    end
    return 0;
  endfunction

  // Flame key: row<<6 | col<<1 | chain, matching {flame_row, flame_col, chain_hit}.
  function automatic void modelExplode(int r, int c);
    int dr[4] = '{-1, 1, 0, 0};
    int dc[4] = '{0, 0, -1, 1};
    refMap[r][c] = T_EMPTY;
    flameQ.push_back((r << 6) | (c << 1));
    for (int d = 0; d < 4; d++) begin
      for (int k = 1; k <= R; k++) begin
        int nr, nc;
        nr = r + dr[d] * k;
        nc = c + dc[d] * k;
        if (nr < 0 || nr >= NR || nc < 0 || nc >= NC) break;
        if (refMap[nr][nc] == T_HARD) break;
        if (refMap[nr][nc] == T_BRICK) begin
          refMap[nr][nc] = T_EMPTY;
          flameQ.push_back((nr << 6) | (nc << 1));
          break;
        end
        if (refMap[nr][nc] == T_BOMB) begin
          flameQ.push_back((nr << 6) | (nc << 1) | 1);
          break;
        end
        flameQ.push_back((nr << 6) | (nc << 1));
      end
    end
  endfunction

  // Monitor: every DUT strobe is matched against the head of its queue.
  always @(negedge clk) begin
    if (resetN) begin
      if (flame_valid && !sweepUnchecked) begin
        if (flameQ.size() == 0) failNote("flame_unexpected", int'({flame_row, flame_col}));
        else begin
          int e;
          e = flameQ.pop_front();
          check("flame_tile", {22'd0, flame_row, flame_col, chain_hit}, 32'(e));
        end
      end
      if (chain_hit && !flame_valid) failNote("chain_without_flame", 1);
      if (place_ack) begin
        if (placeQ.size() == 0) failNote("place_ack_unexpected", int'(place_ok));
        else check("place_ok", {31'd0, place_ok}, 32'(placeQ.pop_front()));
      end
      if (qry_rvalid) begin
        if (qryQ.size() == 0) failNote("qry_rvalid_unexpected", int'(qry_tile));
        else begin
          check("qry_tile", {30'd0, qry_tile}, 32'(qryQ.pop_front()));
          check("qry_latency", 32'(cyc - qryCycQ.pop_front()), 32'd1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitOut(input int sel, input string name, output int atCyc);
    atCyc = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if ((sel == 0 && place_ack) || (sel == 1 && explode_ack) || (sel == 2 && explode_done)) begin
        atCyc = cyc;
        break;
      end
    end
    if (atCyc < 0) failNote({name, "_timeout"}, 0);
  endtask

  task automatic doPlace(input int r, input int c);
    int a;
    placeQ.push_back(modelPlace(r, c));
    place_row = 4'(r);
    place_col = 5'(c);
    place_req = 1'b1;
    waitOut(0, "place_ack", a);
    tick();
    place_req = 1'b0;
  endtask

  task automatic doExplode(input int r, input int c);
    int a, d;
    modelExplode(r, c);
    explode_row = 4'(r);
    explode_col = 5'(c);
    explode_req = 1'b1;
    waitOut(1, "explode_ack", a);
    tick();
    explode_req = 1'b0;
    waitOut(2, "explode_done", d);
    if (a >= 0 && d >= 0) check("done_latency", 32'(d - a), 32'(2 + 4 * R));
    tick();
  endtask

  task automatic doCollision(input int er, input int ec, input int pr, input int pc);
    int a, d, p;
    modelExplode(er, ec);
    placeQ.push_back(modelPlace(pr, pc));
    explode_row = 4'(er);
    explode_col = 5'(ec);
    place_row   = 4'(pr);
    place_col   = 5'(pc);
    explode_req = 1'b1;
    place_req   = 1'b1;
    waitOut(1, "explode_ack", a);
    tick();
    explode_req = 1'b0;
    waitOut(2, "explode_done", d);
    waitOut(0, "place_ack", p);
    if (a >= 0 && d >= 0) check("done_latency", 32'(d - a), 32'(2 + 4 * R));
    if (d >= 0 && p >= 0) check("place_after_done", 32'(p - d), 32'd1);
    tick();
    place_req = 1'b0;
  endtask

  task automatic qryOne(input int r, input int c);
    qryQ.push_back((r < NR && c < NC) ? refMap[r][c] : T_HARD);
    qryCycQ.push_back(cyc);
    qry_row   = 4'(r);
    qry_col   = 5'(c);
    qry_valid = 1'b1;
    tick();
    qry_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    modelReset();
    repeat (3) @(posedge clk);
    #2 resetN = 1'b1;
    @(negedge clk);
    check("reset_outputs", {19'd0, place_ack, place_ok, explode_ack, explode_busy, explode_done,
                            flame_valid, flame_row, flame_col, chain_hit, qry_tile, qry_rvalid}, 32'd0);
    tick();

    qryOne(1, 1); qryOne(0, 3); qryOne(0, 0); qryOne(13, 0);
    tick();

    doPlace(0, 0); qryOne(0, 0);
    doPlace(1, 1); qryOne(1, 1);
    doExplode(0, 0); qryOne(0, 0);
    doExplode(2, 2); qryOne(2, 3); qryOne(2, 4);
    doPlace(0, 2); doExplode(0, 0); qryOne(0, 2);
    doCollision(6, 6, 4, 4); qryOne(4, 4); qryOne(6, 7);
    tick();

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: doPlace(int'($urandom_range(0, 14)), int'($urandom_range(0, 20)));
        1: begin
          int r, c;
          r = int'($urandom_range(0, NR - 1));
          c = int'($urandom_range(0, NC - 1));
          if ($urandom_range(0, 1) == 1) doPlace(int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NC - 1)));
          doExplode(r, c);
        end
        2: begin
          for (int q = 0; q < 4; q++) qryOne(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)));
          tick();
        end
        default: doCollision(int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NC - 1)),
                             int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NC - 1)));
      endcase
    end

    // Reset in the middle of a sweep: map reverts and the sweep never completes.
    sweepUnchecked = 1'b1;
    explode_row = 4'd2;
    explode_col = 5'd2;
    explode_req = 1'b1;
    waitOut(1, "explode_ack_rst", seen);
    tick();
    explode_req = 1'b0;
    repeat (3) tick();
    resetN = 1'b0;
    tick();
    check("busy_in_reset", {31'd0, explode_busy}, 32'd0);
    tick();
    resetN = 1'b1;
    modelReset();
    sweepUnchecked = 1'b0;
    seen = 0;
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      if (explode_done || flame_valid) seen = 1;
    end
    check("no_done_after_reset", 32'(seen), 32'd0);
    tick();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        qryOne(r, c);
    repeat (3) tick();

    check("flame_queue_drained", 32'(flameQ.size()), 32'd0);
    check("place_queue_drained", 32'(placeQ.size()), 32'd0);
    check("qry_queue_drained", 32'(qryQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
